// File: rtl/alarm_match_ringer.sv
// Alarm comparator and ringer: compares MM:SS time digits against alarm digits, rings on match
// entry and handles dismiss, timeout and (with `define ALARM_SNOOZE_EN) snooze with a per-event limit.
module alarm_match_ringer #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 120,
    parameter int unsigned TONE_DIV   = 50000,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       secTick,
    input  logic [3:0] binCOS,
    input  logic [3:0] binCTS,
    input  logic [3:0] binCOM,
    input  logic [3:0] binCTM,
    input  logic [3:0] binAOS,
    input  logic [3:0] binATS,
    input  logic [3:0] binAOM,
    input  logic [3:0] binATM,
    input  logic       alarmEnable,
    input  logic       clearAlarm,
    input  logic       snoozeBtn,
    output logic       alarmActive,
    output logic       snoozeActive,
    output logic       buzzer,
    output logic       ledBlink,
    output logic       alarmInvalid
);

    localparam int unsigned RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_RINGING = 2'd2
`ifdef ALARM_SNOOZE_EN
        , S_SNOOZE = 2'd3
`endif
    } state_e;

    state_e state_q, state_d;

    logic invalid, match, match_q, match_rise;
    logic invalid_q;
    logic snz_meta_q, snz_sync_q, snz_prev_q, snooze_rise;
    logic in_ring, in_snooze, ring_last, ring_stays;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic buzzer_q, buzzer_d;
    logic led_q, led_d;

`ifdef ALARM_SNOOZE_EN
    localparam int unsigned SNZ_W = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
    localparam int unsigned EVT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
    logic [EVT_W-1:0] snooze_cnt_q, snooze_cnt_d;
    logic snz_last, snooze_spent;

    assign in_snooze    = (state_q == S_SNOOZE);
    assign snz_last     = (snz_cnt_q == SNZ_W'(SNOOZE_SEC - 1));
    assign snooze_spent = (snooze_cnt_q == EVT_W'(MAX_SNOOZE));
`else
    logic unused_snooze_cfg;

    assign in_snooze         = 1'b0;
    assign unused_snooze_cfg = ^{SNOOZE_SEC, MAX_SNOOZE};
`endif

    // Out-of-range alarm digits can never be reached by the clock, so they suppress matching.
    assign invalid    = (binAOS > 4'd9) | (binATS > 4'd5) | (binAOM > 4'd9) | (binATM > 4'd5);
    assign match      = (binCOS == binAOS) && (binCTS == binATS) &&
                        (binCOM == binAOM) && (binCTM == binATM) && !invalid;
    assign match_rise = match & ~match_q;

    assign snooze_rise = snz_sync_q & ~snz_prev_q;
    assign in_ring     = (state_q == S_RINGING);
    assign ring_last   = (ring_cnt_q == RING_W'(RING_SEC - 1));
    assign ring_stays  = in_ring && (state_d == S_RINGING);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (alarmEnable) state_d = S_ARMED;
            S_ARMED:   if (match_rise)  state_d = S_RINGING;
            S_RINGING: begin
                if (clearAlarm) begin
                    state_d = S_ARMED;
                end else if (snooze_rise) begin
`ifdef ALARM_SNOOZE_EN
                    state_d = snooze_spent ? S_ARMED : S_SNOOZE;
`else
                    state_d = S_ARMED;
`endif
                end else if (secTick && ring_last) begin
                    state_d = S_ARMED;
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (clearAlarm)                 state_d = S_ARMED;
                else if (secTick && snz_last)   state_d = S_RINGING;
            end
`endif
            default:   state_d = S_IDLE;
        endcase
        if (!alarmEnable) state_d = S_IDLE;
    end

    always_comb begin
        ring_cnt_d = ring_cnt_q;
        tone_cnt_d = '0;
        buzzer_d   = 1'b0;
        led_d      = led_q;

        if (state_d == S_RINGING && !in_ring) begin
            ring_cnt_d = '0;
        end else if (in_ring && secTick && !ring_last) begin
            ring_cnt_d = ring_cnt_q + RING_W'(1);
        end

        // The tone only advances while ringing continues, so it is already 0 the cycle after exit.
        if (ring_stays) begin
            if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
                buzzer_d = ~buzzer_q;
            end else begin
                tone_cnt_d = tone_cnt_q + TONE_W'(1);
                buzzer_d   = buzzer_q;
            end
        end

        if (state_d == S_IDLE || state_d == S_ARMED) begin
            led_d = 1'b0;
        end else if (secTick && (in_ring || in_snooze)) begin
            led_d = ~led_q;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_comb begin
        snz_cnt_d    = snz_cnt_q;
        snooze_cnt_d = snooze_cnt_q;

        if (state_d == S_SNOOZE && !in_snooze) begin
            snz_cnt_d = '0;
        end else if (in_snooze && secTick && !snz_last) begin
            snz_cnt_d = snz_cnt_q + SNZ_W'(1);
        end

        if (state_d == S_ARMED && state_q != S_ARMED) begin
            snooze_cnt_d = '0;
        end else if (in_ring && state_d == S_SNOOZE && !snooze_spent) begin
            snooze_cnt_d = snooze_cnt_q + EVT_W'(1);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            match_q      <= 1'b1;
            invalid_q    <= 1'b0;
            snz_meta_q   <= 1'b0;
            snz_sync_q   <= 1'b0;
            snz_prev_q   <= 1'b0;
            ring_cnt_q   <= '0;
            tone_cnt_q   <= '0;
            buzzer_q     <= 1'b0;
            led_q        <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q    <= '0;
            snooze_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            match_q      <= match;
            invalid_q    <= invalid;
            snz_meta_q   <= snoozeBtn;
            snz_sync_q   <= snz_meta_q;
            snz_prev_q   <= snz_sync_q;
            ring_cnt_q   <= ring_cnt_d;
            tone_cnt_q   <= tone_cnt_d;
            buzzer_q     <= buzzer_d;
            led_q        <= led_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q    <= snz_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
`endif
        end
    end

    assign alarmActive  = in_ring;
    assign snoozeActive = in_snooze;
    assign buzzer       = buzzer_q;
    assign ledBlink     = led_q;
    assign alarmInvalid = invalid_q;

endmodule

// File: tb/tb_alarm_match_ringer.sv
// Self-checking bench for alarm_match_ringer: directed scenarios plus randomized stimulus,
// every cycle compared against a behavioural model of the ringer.
module tb_alarm_match_ringer;

    localparam int RING_SEC    = 3;
    localparam int SNOOZE_SEC  = 2;
    localparam int TONE_DIV    = 4;
    localparam int MAX_SNOOZE  = 1;
    localparam int TICK_PERIOD = 10;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNOOZE_EN = 1'b1;
`else
    localparam bit SNOOZE_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_ARMED = 1, M_RINGING = 2, M_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       secTick;
    logic [3:0] binCOS, binCTS, binCOM, binCTM;
    logic [3:0] binAOS, binATS, binAOM, binATM;
    logic       alarmEnable, clearAlarm, snoozeBtn;
    logic       alarmActive, snoozeActive, buzzer, ledBlink, alarmInvalid;

    always #5 clk = ~clk;

    alarm_match_ringer #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .TONE_DIV   (TONE_DIV),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .secTick      (secTick),
        .binCOS       (binCOS),
        .binCTS       (binCTS),
        .binCOM       (binCOM),
        .binCTM       (binCTM),
        .binAOS       (binAOS),
        .binATS       (binATS),
        .binAOM       (binAOM),
        .binATM       (binATM),
        .alarmEnable  (alarmEnable),
        .clearAlarm   (clearAlarm),
        .snoozeBtn    (snoozeBtn),
        .alarmActive  (alarmActive),
        .snoozeActive (snoozeActive),
        .buzzer       (buzzer),
        .ledBlink     (ledBlink),
        .alarmInvalid (alarmInvalid)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: mode plus elapsed-seconds / elapsed-cycles bookkeeping.
    int m_mode, m_ring_secs, m_snz_secs, m_snoozes, m_ring_cycles;
    bit m_led, m_prev_match, m_invalid;
    bit m_btn [4];
    int cyc;
    bit last_tick;

    task automatic model_reset();
        m_mode        = M_IDLE;
        m_ring_secs   = 0;
        m_snz_secs    = 0;
        m_snoozes     = 0;
        m_ring_cycles = 0;
        m_led         = 1'b0;
        m_prev_match  = 1'b1;
        m_invalid     = 1'b0;
        for (int i = 0; i < 4; i++) m_btn[i] = 1'b0;
    endtask

    task automatic model_step();
        bit match_now, mrise, srise, tick;
        int old_mode, new_mode;
        m_invalid = (binAOS > 9) || (binATS > 5) || (binAOM > 9) || (binATM > 5);
        match_now = (binCOS == binAOS) && (binCTS == binATS) && (binCOM == binAOM) &&
                    (binCTM == binATM) && !m_invalid;
        mrise        = match_now && !m_prev_match;
        m_prev_match = match_now;
        m_btn[3] = m_btn[2];
        m_btn[2] = m_btn[1];
        m_btn[1] = m_btn[0];
        m_btn[0] = snoozeBtn;
        srise    = m_btn[2] && !m_btn[3];
        tick     = secTick;

        old_mode = m_mode;
        new_mode = old_mode;
        case (old_mode)
            M_IDLE:    if (alarmEnable) new_mode = M_ARMED;
            M_ARMED:   if (mrise) new_mode = M_RINGING;
            M_RINGING: begin
                if (clearAlarm) new_mode = M_ARMED;
                else if (srise) new_mode = (SNOOZE_EN && m_snoozes < MAX_SNOOZE) ? M_SNOOZE : M_ARMED;
                else if (tick && m_ring_secs + 1 == RING_SEC) new_mode = M_ARMED;
            end
            M_SNOOZE: begin
                if (clearAlarm) new_mode = M_ARMED;
                else if (tick && m_snz_secs + 1 == SNOOZE_SEC) new_mode = M_RINGING;
            end
            default: new_mode = M_IDLE;
        endcase
        if (!alarmEnable) new_mode = M_IDLE;

        if (old_mode == M_RINGING && new_mode == M_RINGING) begin
            m_ring_secs   += int'(tick);
            m_ring_cycles += 1;
        end else begin
            m_ring_secs   = 0;
            m_ring_cycles = 0;
        end
        if (old_mode == M_SNOOZE && new_mode == M_SNOOZE) m_snz_secs += int'(tick);
        else m_snz_secs = 0;
        if (old_mode == M_RINGING && new_mode == M_SNOOZE) m_snoozes++;
        if (new_mode == M_ARMED && old_mode != M_ARMED) m_snoozes = 0;

        if (new_mode == M_IDLE || new_mode == M_ARMED) m_led = 1'b0;
        else if (tick && (old_mode == M_RINGING || old_mode == M_SNOOZE)) m_led = ~m_led;
        m_mode = new_mode;
    endtask

    task automatic compare_outputs();
        bit exp_buzz;
        exp_buzz = (m_mode == M_RINGING) ? bit'((m_ring_cycles / TONE_DIV) % 2) : 1'b0;
        check({phase, ".alarmActive"},  alarmActive,  m_mode == M_RINGING);
        check({phase, ".snoozeActive"}, snoozeActive, m_mode == M_SNOOZE);
        check({phase, ".buzzer"},       buzzer,       exp_buzz);
        check({phase, ".ledBlink"},     ledBlink,     m_led);
        check({phase, ".alarmInvalid"}, alarmInvalid, m_invalid);
    endtask

    // Inputs change at the falling edge; outputs are compared at the following falling edge.
    task automatic run_cycle();
        secTick   = (cyc % TICK_PERIOD == TICK_PERIOD - 1);
        last_tick = secTick;
        cyc++;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) run_cycle();
    endtask

    task automatic run_count_ring(input int n, output int ring_cycles);
        ring_cycles = 0;
        repeat (n) begin
            run_cycle();
            ring_cycles += int'(alarmActive === 1'b1);
        end
    endtask

    task automatic set_time(input int mm, input int ss);
        binCTM = 4'(mm / 10); binCOM = 4'(mm % 10);
        binCTS = 4'(ss / 10); binCOS = 4'(ss % 10);
    endtask

    task automatic press_snooze();
        snoozeBtn = 1'b1;
        run(3);
        snoozeBtn = 1'b0;
    endtask

    task automatic start_ring();
        set_time(12, 33);
        run(2);
        set_time(12, 34);
        run_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, rings, edges;
        bit prev_buzz;

        rst_n = 1'b0;
        secTick = 1'b0;
        binATM = 4'd1; binAOM = 4'd2; binATS = 4'd3; binAOS = 4'd4;
        set_time(12, 34);
        alarmEnable = 1'b1;
        clearAlarm  = 1'b0;
        snoozeBtn   = 1'b0;
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        phase = "reset";
        compare_outputs();

        rst_n = 1'b1;
        phase = "reset_exit";
        run_count_ring(15, rings);
        check("reset_exit_no_ring", rings, 0);

        phase = "first_match";
        set_time(12, 33);
        run(5);
        check("pre_match_idle", alarmActive, 1'b0);
        set_time(12, 34);
        run_cycle();
        check("ring_latency", alarmActive, 1'b1);

        phase = "tone";
        ticks = 0;
        edges = 0;
        prev_buzz = buzzer;
        repeat (16) begin
            run_cycle();
            ticks += int'(last_tick);
            edges += int'(buzzer != prev_buzz);
            prev_buzz = buzzer;
        end
        check("buzzer_edges_16clk", edges, 4);

        phase = "timeout";
        for (int i = 0; i < 60; i++) begin
            run_cycle();
            ticks += int'(last_tick);
            if (alarmActive !== 1'b1) break;
        end
        check("timeout_ticks", ticks, RING_SEC);
        check("timeout_buzzer", buzzer, 1'b0);
        run_count_ring(40, rings);
        check("single_ring_per_match", rings, 0);

        phase = "snooze";
        start_ring();
        press_snooze();
        check("snooze_press_ring", alarmActive, 1'b0);
        check("snooze_press_snz", snoozeActive, SNOOZE_EN);
        run(22);
        check("snooze_rering", alarmActive, SNOOZE_EN);
        press_snooze();
        run(1);
        check("second_press_ring", alarmActive, 1'b0);
        check("second_press_snz", snoozeActive, 1'b0);

        phase = "clear_vs_snooze";
        start_ring();
        clearAlarm = 1'b1;
        snoozeBtn  = 1'b1;
        run_cycle();
        clearAlarm = 1'b0;
        run(3);
        snoozeBtn = 1'b0;
        run(2);
        check("clear_wins_snz", snoozeActive, 1'b0);
        check("clear_wins_ring", alarmActive, 1'b0);

        phase = "disable";
        start_ring();
        press_snooze();
        run(2);
        alarmEnable = 1'b0;
        run_cycle();
        check("disable_ring", alarmActive, 1'b0);
        check("disable_snz", snoozeActive, 1'b0);
        check("disable_led", ledBlink, 1'b0);
        alarmEnable = 1'b1;
        run(2);

        phase = "invalid";
        set_time(12, 33);
        run(3);
        binAOS = 4'hA;
        run_cycle();
        check("invalid_flag", alarmInvalid, 1'b1);
        binCOS = 4'hA;
        run_count_ring(20, rings);
        check("invalid_no_ring", rings, 0);
        binAOS = 4'd4;
        set_time(12, 33);
        run_cycle();
        check("invalid_cleared", alarmInvalid, 1'b0);

        phase = "reset_mid_ring";
        start_ring();
        run(6);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ring", alarmActive, 1'b0);
        check("rst_async_snz", snoozeActive, 1'b0);
        check("rst_async_buzzer", buzzer, 1'b0);
        check("rst_async_led", ledBlink, 1'b0);
        check("rst_async_invalid", alarmInvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_count_ring(15, rings);
        check("rst_exit_match_no_ring", rings, 0);
        start_ring();
        check("rst_exit_next_match_rings", alarmActive, 1'b1);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 10) begin
                case ($urandom_range(0, 2))
                    0: begin
                        binCOS = binAOS; binCTS = binATS; binCOM = binAOM; binCTM = binATM;
                    end
                    1: set_time(12, 33);
                    default: set_time(int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
                endcase
            end
            if ($urandom_range(0, 399) == 0) binAOS = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) binAOS = 4'd4;
            alarmEnable = ($urandom_range(0, 299) != 0);
            clearAlarm  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 14) == 0) snoozeBtn = ~snoozeBtn;
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
